// File: rtl/m_stage_dm_if.sv
// EX/MEM-to-data-memory bundle: the instruction context presented by the
// pipeline and the load result, stall and error flags returned by the DM.
interface m_stage_dm_if;
  logic [31:0] M_PC;       // PC of the instruction in MEM (store log only)
  logic [31:0] M_Instr;    // instruction in MEM, 0 = bubble
  logic [31:0] M_ALUAns;   // effective byte address
  logic [31:0] M_rt_data;  // store data, already forwarded
  logic        stall;      // access still pending
  logic [31:0] rd_data;    // extended load result
  logic        addr_err;   // misaligned or out-of-range access

  // Pipeline side: drives the EX/MEM values, observes DM results.
  modport master (
    output M_PC, M_Instr, M_ALUAns, M_rt_data,
    input  stall, rd_data, addr_err
  );

  // Data-memory side.
  modport slave (
    input  M_PC, M_Instr, M_ALUAns, M_rt_data,
    output stall, rd_data, addr_err
  );
endinterface

// File: rtl/m_stage_dm.sv
// MEM-stage data memory: decodes the load/store in MEM, holds the pipeline
// for WAIT_CYCLES cycles, then performs the access on a word-organised RAM
// with little-endian byte/half lanes and sign/zero extension of loads.
module m_stage_dm #(
  parameter int ADDR_WORDS  = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  m_stage_dm_if.slave bus
);

  localparam int          IDX_W      = $clog2(ADDR_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * ADDR_WORDS);
  localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic  load;
    logic  store;
    size_e size;
    logic  sext;
  } dec_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage and FSM state
  // ---------------------------------------------------------------------------
  logic [31:0] mem [ADDR_WORDS];
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Decode and address checks
  // ---------------------------------------------------------------------------
  dec_t             dec;
  logic             mem_op;
  logic [31:0]      addr;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             in_range;
  logic             err;

  assign addr = bus.M_ALUAns;
  assign idx  = addr[IDX_W+1:2];

  // Opcode decode into access kind, size and extension mode.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    dec = '0;
    case (bus.M_Instr[31:26])
      OP_LW:   begin dec.load  = 1'b1; dec.size = SZ_WORD;                 end
      OP_LH:   begin dec.load  = 1'b1; dec.size = SZ_HALF; dec.sext = 1'b1; end
      OP_LHU:  begin dec.load  = 1'b1; dec.size = SZ_HALF;                 end
      OP_LB:   begin dec.load  = 1'b1; dec.size = SZ_BYTE; dec.sext = 1'b1; end
      OP_LBU:  begin dec.load  = 1'b1; dec.size = SZ_BYTE;                 end
      OP_SW:   begin dec.store = 1'b1; dec.size = SZ_WORD;                 end
      OP_SH:   begin dec.store = 1'b1; dec.size = SZ_HALF;                 end
      OP_SB:   begin dec.store = 1'b1; dec.size = SZ_BYTE;                 end
      default: dec = '0;
    endcase
  end

  assign mem_op = dec.load | dec.store;

  // Alignment is judged against the access size; bytes are always aligned.
  always_comb begin
    misaligned = 1'b0;
    case (dec.size)
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      SZ_HALF: misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  assign in_range = (addr < ADDR_LIMIT);
  assign err      = mem_op && (misaligned || !in_range);

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
  logic stall;
  logic access;

  // Next state, counter and stall. Non-memory instructions leave it untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    access  = 1'b0;
    if (mem_op) begin
      case (state_q)
        S_IDLE: begin
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            stall   = 1'b1;
          end else begin
            access  = 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            stall = 1'b1;
          end else begin
            state_d = S_IDLE;
            access  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State register; reset returns to IDLE and abandons any pending access.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and lane merge
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic        we;

  // Out-of-range addresses never index the array; the result is masked anyway.
  assign rd_word = in_range ? mem[idx] : 32'h0;
  assign byte_v  = rd_word[{addr[1:0], 3'b000} +: 8];
  assign half_v  = rd_word[{addr[1], 4'b0000} +: 16];

  // Store data merged into the current word; untouched lanes keep old bytes.
  always_comb begin
    wr_word = rd_word;
    case (dec.size)
      SZ_WORD: wr_word = bus.M_rt_data;
      SZ_HALF: wr_word[{addr[1], 4'b0000} +: 16]   = bus.M_rt_data[15:0];
      default: wr_word[{addr[1:0], 3'b000} +: 8]  = bus.M_rt_data[7:0];
    endcase
  end

  // Load extension by size and signedness.
  always_comb begin
    load_v = 32'h0;
    case (dec.size)
      SZ_WORD: load_v = rd_word;
      SZ_HALF: load_v = {{16{dec.sext & half_v[15]}}, half_v};
      default: load_v = {{24{dec.sext & byte_v[7]}}, byte_v};
    endcase
  end

  assign we = access && dec.store && !err;

  // RAM: cleared by reset, written only on the access-cycle edge of a good store.
  // NOTE: the RAM is reset explicitly because software relies on zeroed data
  // memory after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ADDR_WORDS; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (we) begin
      mem[idx] <= wr_word;
    end
  end

`ifndef SYNTHESIS
  // Store trace for simulation: one line per committed store.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      $display("%d@%h: *%h <= %h", $time, bus.M_PC, {addr[31:2], 2'b00}, wr_word);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.stall    = stall;
  assign bus.addr_err = err;
  assign bus.rd_data  = (dec.load && !err) ? load_v : 32'h0;

endmodule

// File: tb/tb_m_stage_dm.sv
// Bench for m_stage_dm: one instance with two wait states and one single-cycle
// instance, checked against a byte-addressed memory model and cycle counts.
module tb_m_stage_dm;

  localparam int WORDS = 3072;
  localparam int BYTES = 4 * WORDS;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  m_stage_dm_if if_a ();
  m_stage_dm_if if_b ();

  m_stage_dm #(.ADDR_WORDS(WORDS), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  m_stage_dm #(.ADDR_WORDS(WORDS), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [BYTES];
  logic [7:0] mem_b [BYTES];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic int size_of(input logic [5:0] op);
    if (op inside {OP_LW, OP_SW}) return 4;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 1;
  endfunction

  function automatic bit model_err(input logic [5:0] op, input logic [31:0] a);
    int unsigned sz;
    sz = size_of(op);
    return ((a % sz) != 0) || (a >= 32'(BYTES));
  endfunction

  function automatic logic [7:0] rdb(input bit sel, input logic [31:0] a);
    return sel ? mem_b[a] : mem_a[a];
  endfunction

  function automatic logic [31:0] model_load(input bit sel, input logic [5:0] op, input logic [31:0] a);
    logic [15:0] h;
    logic [7:0]  b;
    h = {rdb(sel, a + 1), rdb(sel, a)};
    b = rdb(sel, a);
    case (op)
      OP_LW:   return {rdb(sel, a + 3), rdb(sel, a + 2), h};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      OP_LB:   return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  task automatic model_store(input bit sel, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < size_of(op); i++) begin
      if (sel) mem_b[a + i] = d[8*i +: 8];
      else     mem_a[a + i] = d[8*i +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) begin
      mem_a[i] = 8'h0;
      mem_b[i] = 8'h0;
    end
  endtask

  // ---------------- drive / observe ----------------
  task automatic drive(input bit sel, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc);
    if (sel) begin
      if_b.M_Instr = instr; if_b.M_ALUAns = a; if_b.M_rt_data = d; if_b.M_PC = pc;
    end else begin
      if_a.M_Instr = instr; if_a.M_ALUAns = a; if_a.M_rt_data = d; if_a.M_PC = pc;
    end
  endtask

  function automatic logic obs_stall(input bit sel);
    return sel ? if_b.stall : if_a.stall;
  endfunction

  function automatic logic obs_err(input bit sel);
    return sel ? if_b.addr_err : if_a.addr_err;
  endfunction

  function automatic logic [31:0] obs_rd(input bit sel);
    return sel ? if_b.rd_data : if_a.rd_data;
  endfunction

  // One instruction from first presentation to the edge ending its access cycle.
  task automatic exec(input bit sel, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] pc, output logic [31:0] rd_seen);
    bit          mem, st, e;
    int          w;
    logic [31:0] er;
    mem = is_load(op) || is_store(op);
    st  = is_store(op);
    w   = (mem && !sel) ? 2 : 0;
    e   = mem && model_err(op, a);
    er  = (is_load(op) && !e) ? model_load(sel, op, a) : 32'h0;
    rd_seen = 32'h0;
    drive(sel, {op, 26'($urandom)}, a, d, pc);
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      check("stall", 32'(obs_stall(sel)), 32'(c < w));
      check("addr_err", 32'(obs_err(sel)), 32'(e));
      if (c == w) begin
        rd_seen = obs_rd(sel);
        if (!st) check("rd_data", rd_seen, er);
      end
      @(posedge clk); #1;
    end
    if (st && !e) model_store(sel, op, a, d);
    drive(sel, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic bubble(input bit sel);
    drive(sel, 32'h0, 32'($urandom), 32'($urandom), 32'h0);
    @(negedge clk);
    check("bubble_stall", 32'(obs_stall(sel)), 32'h0);
    check("bubble_err", 32'(obs_err(sel)), 32'h0);
    check("bubble_rd", obs_rd(sel), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Reset raised after k cycles of a pending sw @0x20 on the two-wait instance.
  task automatic reset_mid_store(input int k);
    logic [31:0] r;
    drive(1'b0, {OP_SW, 26'h0}, 32'h20, 32'hDEADBEEF, 32'h4000);
    for (int c = 0; c < k; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_stall", 32'(obs_stall(1'b0)), 32'h0);
    @(posedge clk); #1;
    exec(1'b0, OP_LW, 32'h20, 32'h0, 32'h4004, r);
    check("rst_lw20", r, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(input logic [5:0] op);
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = 32'($urandom_range(0, 63));
      2:       a = 32'(BYTES - 8) + 32'($urandom_range(0, 15));
      default: a = $urandom();
    endcase
    if ($urandom_range(0, 1) == 1) a = a & ~32'(size_of(op) - 1);
    return a;
  endfunction

  logic [5:0] op_tab [10] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
                              OP_SW, OP_SH, OP_SB, 6'b000000, 6'b001000};

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    do_reset();

    // Reset state: no stall, no error, zero result on a bubble.
    bubble(1'b0);
    bubble(1'b1);

    // Directed sequence on the two-wait instance.
    exec(1'b0, OP_LW, 32'h0, 32'h0, 32'h1000, r);
    check("lw0", r, 32'h0);
    exec(1'b0, OP_SW, 32'h10, 32'h12345678, 32'h3000, r);
    exec(1'b0, OP_LW, 32'h10, 32'h0, 32'h3004, r);
    check("lw10", r, 32'h12345678);
    exec(1'b0, OP_SB, 32'h11, 32'h000000AB, 32'h3008, r);
    exec(1'b0, OP_SH, 32'h12, 32'h0000CDEF, 32'h300C, r);
    exec(1'b0, OP_LW, 32'h10, 32'h0, 32'h3010, r);
    check("merge", r, 32'hCDEFAB78);
    exec(1'b0, OP_LB, 32'h11, 32'h0, 32'h3014, r);
    check("lb11", r, 32'hFFFFFFAB);
    exec(1'b0, OP_LBU, 32'h11, 32'h0, 32'h3018, r);
    check("lbu11", r, 32'h000000AB);
    exec(1'b0, OP_LH, 32'h12, 32'h0, 32'h301C, r);
    check("lh12", r, 32'hFFFFCDEF);
    exec(1'b0, OP_LHU, 32'h12, 32'h0, 32'h3020, r);
    check("lhu12", r, 32'h0000CDEF);
    bubble(1'b0);

    // Errors: misaligned store leaves RAM alone; out-of-range load reads 0.
    exec(1'b0, OP_SW, 32'h2, 32'hFFFFFFFF, 32'h3024, r);
    exec(1'b0, OP_LW, 32'h0, 32'h0, 32'h3028, r);
    check("sw2_nowrite", r, 32'h0);
    exec(1'b0, OP_LW, 32'h3000, 32'h0, 32'h302C, r);
    check("lw3000", r, 32'h0);
    exec(1'b0, OP_LW, 32'h2FFC, 32'h0, 32'h3030, r);

    // Reset while a store is pending, in a wait cycle and in the access cycle.
    reset_mid_store(1);
    reset_mid_store(2);

    // Single-cycle instance: store immediately visible to the next load.
    exec(1'b1, OP_SW, 32'h40, 32'hA5A55A5A, 32'h5000, r);
    exec(1'b1, OP_LW, 32'h40, 32'h0, 32'h5004, r);
    check("b_lw40", r, 32'hA5A55A5A);
    exec(1'b1, OP_SB, 32'h43, 32'h00000011, 32'h5008, r);
    exec(1'b1, OP_LW, 32'h40, 32'h0, 32'h500C, r);
    check("b_sb43", r, 32'h11A55A5A);

    // Random mix on both instances, with occasional bubbles.
    for (int i = 0; i < 400; i++) begin
      bit sel;
      sel = (i % 4 == 3);
      op  = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) bubble(sel);
      exec(sel, op, rand_addr(op), $urandom(), 32'($urandom), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait never completes.
  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_stage_dm.md
# m_stage_dm

MEM-stage data-memory unit of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs (`M_PC`, `M_Instr`, `M_ALUAns`, `M_rt_data`) and decodes the load/store in `M_Instr`. It performs the access against an internal word-organised RAM with a configurable number of wait states. While an access is outstanding it asserts `stall`, which the hazard unit uses to hold the PC, F/D, D/E and E/M registers.

## Interface
- `ADDR_WORDS`, 3072 — RAM depth in 32-bit words (12 KiB, byte addresses 0x0000–0x2FFF).
- `WAIT_CYCLES`, 2 — stall cycles per memory instruction; range 0–15, where 0 means single-cycle access.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `M_PC`  in  32  PC of the instruction in MEM; used only for the store log.
- `M_Instr`  in  32  instruction in MEM; 0 means nop/bubble.
- `M_ALUAns`  in  32  effective byte address.
- `M_rt_data`  in  32  store data, already forwarded.
- `stall`  out  1  high while the current memory instruction has not reached its access cycle.
- `rd_data`  out  32  extended load result for the MEM/WB register.
- `addr_err`  out  1  current memory instruction is misaligned or out of range.

## Operation
- Decode `M_Instr[31:26]`:
  - loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
  - stores: sw 101011, sh 101001, sb 101000
  - every other opcode is a non-memory instruction: `stall`=0, `rd_data`=0, `addr_err`=0, FSM untouched.
- Word index = `M_ALUAns[13:2]`. Byte lanes are little-endian: offset 0 is bits 7:0.
- `addr_err` = 1 in either case:
  - misaligned: word access with `addr[1:0]`≠0, or half access with `addr[0]`≠0;
  - out of range: `addr` ≥ 4*`ADDR_WORDS`.
- On error: no RAM write, `rd_data`=0. Stall timing is unchanged, so errors still take `WAIT_CYCLES`.
- Stores, written only on the access-cycle edge:
  - sw writes the whole word;
  - sh writes `M_rt_data[15:0]` into half `addr[1]`;
  - sb writes `M_rt_data[7:0]` into byte `addr[1:0]`;
  - other lanes are preserved.
- Store log: in the same access-cycle edge, emit `$display("%d@%h: *%h <= %h", $time, M_PC, {addr[31:2],2'b00}, merged_word)`. Simulation only; excluded from synthesis.
- Loads: `rd_data` is combinational from the RAM word at the current address. lh and lb sign-extend; lhu and lbu zero-extend.
- FSM states:
  - IDLE: on a memory instruction with `WAIT_CYCLES`>0, go to WAIT and load `cnt` ← `WAIT_CYCLES`−1. With `WAIT_CYCLES`=0, stay in IDLE; the present cycle is the access cycle.
  - WAIT: if `cnt`≠0, `cnt` ← `cnt`−1. If `cnt`=0, this is the access cycle; return to IDLE.
- `stall` = mem_op && ((state==IDLE && `WAIT_CYCLES`≠0) || (state==WAIT && `cnt`≠0)).
- `cnt` is 4 bits.

## Timing
- Reset values: state IDLE, `cnt`=0, every RAM word 0.
  - `stall`, `rd_data` and `addr_err` are combinational, so they are 0 whenever `M_Instr`=0.
- Memory instruction first presented in cycle 0:
  - `stall`=1 in cycles 0 .. `WAIT_CYCLES`−1;
  - `stall`=0 in cycle `WAIT_CYCLES` (the access cycle);
  - the store commits, and `rd_data` is valid for MEM/WB capture, at the rising edge ending the access cycle.
- Total occupancy is `WAIT_CYCLES`+1 cycles. With `WAIT_CYCLES`=0 the unit behaves as a plain single-cycle DM.
- `M_*` inputs are held constant by the pipeline while `stall`=1. The unit does not re-register them.
- Back-to-back memory instructions each pay the full wait. The FSM re-enters WAIT in the cycle after the access cycle.
- Reset during WAIT: the FSM returns to IDLE and the pending store is discarded; reset wins over the access edge. RAM is cleared.
- A load in MEM and a store in the same cycle cannot coexist, since there is one instruction per stage. No RAM read/write collision exists.
- A bubble (`M_Instr`=0) arriving in the cycle after an access cycle sees IDLE and produces no stall.

## Test plan
- Reset, then lw from 0x0 in IDLE with `WAIT_CYCLES`=2 → `stall`=1,1,0 over three cycles; `rd_data`=0x00000000 in cycle 2.
- sw `M_rt_data`=0x12345678 @0x10 with `M_PC`=0x3000 → log line `@00003000: *00000010 <= 12345678` on the third edge only. Next, lw @0x10 → `rd_data`=0x12345678.
- Byte/half merge: sb 0xAB @0x11 then sh 0xCDEF @0x12 over 0x12345678 → word 0xCDEFAB78.
  - lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB;
  - lh @0x12 → 0xFFFFCDEF; lhu @0x12 → 0x0000CDEF.
- Errors:
  - sw @0x2 → `addr_err`=1, RAM unchanged, same 2-cycle stall;
  - lw @0x3000 → `addr_err`=1, `rd_data`=0.
- Reset asserted in the second cycle of a sw @0x20 → `stall` low the next cycle, no log line, lw @0x20 returns 0.
- `WAIT_CYCLES`=0 build: consecutive sw/lw never raise `stall`, and the store is visible to the following lw.
